// File: rtl/frame_snapshot_ctrl.sv
// Single-frame snapshot sequencer: gates capture writes between two vsync edges, then streams
// the frozen frame buffer as a valid/ready pixel stream. Define FRAME_CRC_EN to add crc16.
module frame_snapshot_ctrl #(
   parameter int unsigned NUM_PIXELS     = 76800,
   parameter int unsigned ADDR_W         = 17,
   parameter int unsigned PIX_W          = 12,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              snap_req,
   input  logic              snap_abort,
   input  logic              ov7670_vsync,
   output logic              write_enable,
   output logic [ADDR_W-1:0] retrieve_address,
   input  logic [PIX_W-1:0]  output_data,
   output logic [PIX_W-1:0]  px_data,
   output logic              px_valid,
   input  logic              px_ready,
   output logic              px_sop,
   output logic              px_eop,
   output logic              busy,
   output logic              snap_done,
`ifdef FRAME_CRC_EN
   output logic [15:0]       crc16,
`endif
   output logic              snap_err
);

   typedef enum logic [2:0] {StIdle, StWaitVs, StCapture, StSettle, StReadout, StDone} state_e;

   localparam logic [31:0]       TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]       SettleLast  = 32'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(NUM_PIXELS - 1);

   state_e            state_q, state_d;
   logic              vs_meta_q, vs_sync_q, vs_prev_q, vs_rise_q;
   logic [31:0]       cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              busy_q, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              inflight_q, infl_sop_q, infl_eop_q;
   logic [PIX_W+1:0]  fifo_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        count_q;
   logic [PIX_W+1:0]  head;
   logic              issue, pop, push, flush, space_ok;

   assign head             = fifo_q[rd_ptr_q];
   assign px_valid         = (count_q != 2'd0);
   assign px_data          = head[PIX_W-1:0];
   assign px_sop           = head[PIX_W];
   assign px_eop           = head[PIX_W+1];
   assign pop              = px_valid & px_ready;
   assign push             = inflight_q;
   assign write_enable     = we_q;
   assign retrieve_address = rd_addr_q;
   assign busy             = busy_q;
   assign snap_done        = done_q;
   assign snap_err         = err_q;

   // Room is judged after this cycle's pop so a full-rate consumer keeps one read per cycle.
   assign space_ok = (count_q == 2'd0) ||
                     ((count_q == 2'd1) && (pop || !inflight_q)) ||
                     ((count_q == 2'd2) && pop && !inflight_q);

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         vs_meta_q <= 1'b0;
         vs_sync_q <= 1'b0;
         vs_prev_q <= 1'b0;
         vs_rise_q <= 1'b0;
      end else begin
         vs_meta_q <= ov7670_vsync;
         vs_sync_q <= vs_meta_q;
         vs_prev_q <= vs_sync_q;
         vs_rise_q <= vs_sync_q & ~vs_prev_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      we_d      = we_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rd_addr_d = rd_addr_q;
      issue     = 1'b0;
      flush     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (snap_req) state_d = StWaitVs;
         end
         StWaitVs: begin
            cnt_d = cnt_q + 32'd1;
            if (vs_rise_q) begin
               state_d = StCapture;
               we_d    = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
               we_d    = 1'b0;
            end
         end
         StCapture: begin
            cnt_d = cnt_q + 32'd1;
            if (vs_rise_q) begin
               state_d = StSettle;
               we_d    = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
               we_d    = 1'b0;
            end
         end
         StSettle: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == SettleLast) begin
               state_d   = StReadout;
               rd_addr_d = '0;
            end
         end
         StReadout: begin
            issue = space_ok && (rd_addr_q <= LastAddr);
            if (issue) rd_addr_d = rd_addr_q + 1'b1;
            if (pop && px_eop) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (snap_abort) begin
         state_d = StIdle;
         we_d    = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
         issue   = 1'b0;
         flush   = 1'b1;
      end
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         busy_q    <= (state_d != StIdle);
         done_q    <= done_d;
         err_q     <= err_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         infl_sop_q <= 1'b0;
         infl_eop_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         infl_sop_q <= 1'b0;
         infl_eop_q <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= {infl_eop_q, infl_sop_q, output_data};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q    <= count_q + {1'b0, push} - {1'b0, pop};
         inflight_q <= issue;
         if (issue) begin
            infl_sop_q <= (rd_addr_q == '0);
            infl_eop_q <= (rd_addr_q == LastAddr);
         end
      end
   end

`ifdef FRAME_CRC_EN
   logic [15:0] crc_q;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [PIX_W-1:0] pix);
      logic [15:0] c;
      logic [15:0] d;
      c = crc;
      d = 16'(pix);
      for (int i = 15; i >= 0; i--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else if (state_q != StReadout && state_d == StReadout) begin
         crc_q <= 16'hFFFF;
      end else if (pop && state_q == StReadout) begin
         crc_q <= crc_step(crc_q, px_data);
      end
   end

   assign crc16 = crc_q;
`endif

endmodule

// File: tb/tb_frame_snapshot_ctrl.sv
// Directed-sequence bench with randomized frame contents, vsync timing and consumer backpressure,
// checked against an address-ordered pixel model of the frozen frame.
module tb_frame_snapshot_ctrl;

   localparam int NP = 16;

   logic        clk_50 = 1'b0;
   logic        reset = 1'b1;
   logic        snap_req = 1'b0;
   logic        snap_abort = 1'b0;
   logic        ov7670_vsync = 1'b0;
   logic        px_ready = 1'b1;
   logic [11:0] output_data = '0;
   logic        write_enable;
   logic [16:0] retrieve_address;
   logic [11:0] px_data;
   logic        px_valid, px_sop, px_eop, busy, snap_done, snap_err;
`ifdef FRAME_CRC_EN
   logic [15:0] crc16;
   logic [15:0] last_crc = '0;
   bit          crc_valid = 1'b0;
`endif

   logic [11:0] mem [NP];
   int          checks = 0;
   int          failures = 0;

   frame_snapshot_ctrl #(
      .NUM_PIXELS    (NP),
      .ADDR_W        (17),
      .PIX_W         (12),
      .SETTLE_CYCLES (8),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk_50          (clk_50),
      .reset           (reset),
      .snap_req        (snap_req),
      .snap_abort      (snap_abort),
      .ov7670_vsync    (ov7670_vsync),
      .write_enable    (write_enable),
      .retrieve_address(retrieve_address),
      .output_data     (output_data),
      .px_data         (px_data),
      .px_valid        (px_valid),
      .px_ready        (px_ready),
      .px_sop          (px_sop),
      .px_eop          (px_eop),
      .busy            (busy),
      .snap_done       (snap_done),
`ifdef FRAME_CRC_EN
      .crc16           (crc16),
`endif
      .snap_err        (snap_err)
   );

   always #5 clk_50 = ~clk_50;

   // Synchronous frame buffer read port: data one cycle after the address.
   always @(posedge clk_50) output_data <= mem[retrieve_address[3:0]];

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [11:0] pix);
      logic [15:0] c;
      logic [15:0] d;
      c = crc;
      d = {4'h0, pix};
      for (int b = 15; b >= 0; b--) begin
         if (c[15] ^ d[b]) c = (c << 1) ^ 16'h1021;
         else c = c << 1;
      end
      return c;
   endfunction

   task automatic new_frame();
      foreach (mem[i]) mem[i] = 12'($urandom);
   endtask

   // Ends at the sample right after the capture-ending edge (write_enable just fell).
   task automatic do_capture(input bit extra_req);
      new_frame();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      chk("busy_after_req", busy, 1);
      repeat ($urandom_range(2, 8)) tick();
      ov7670_vsync = 1'b1;
      repeat (3) tick();
      chk("we_before_first_edge", write_enable, 0);
      tick();
      chk("we_rise", write_enable, 1);
      ov7670_vsync = 1'b0;
      repeat ($urandom_range(4, 20)) tick();
      if (extra_req) begin
         snap_req = 1'b1;
         tick();
         snap_req = 1'b0;
         chk("req_ignored_we", write_enable, 1);
         chk("req_ignored_busy", busy, 1);
         repeat (3) tick();
      end
      ov7670_vsync = 1'b1;
      repeat (3) tick();
      chk("we_before_second_edge", write_enable, 1);
      tick();
      chk("we_fall", write_enable, 0);
      ov7670_vsync = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic readout(input int mode, input int abort_after);
      int          n = 0;
      int          first = -1;
      int          last = -1;
      int          done_cyc = -1;
      int          dones = 0;
      bit          stalled = 1'b0;
      bit          aborted = 1'b0;
      logic [13:0] held = '0;
      logic [16:0] max_addr = '0;
      logic [15:0] crc_m = 16'hFFFF;
      for (int cyc = 0; cyc < 200; cyc++) begin
`ifdef FRAME_CRC_EN
         if (cyc == 0 && crc_valid) chk("crc_hold_next", crc16, last_crc);
`endif
         if (snap_done) dones++;
         if (retrieve_address > max_addr) max_addr = retrieve_address;
         if (stalled) chk("stall_hold", {px_valid, px_sop, px_eop, px_data}, {1'b1, held});
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk("done_after_eop", snap_done, 1);
`ifdef FRAME_CRC_EN
            chk("crc_at_done", crc16, crc_m);
`endif
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            chk("idle_after_done", busy, 0);
`ifdef FRAME_CRC_EN
            chk("crc_hold", crc16, crc_m);
            last_crc  = crc_m;
            crc_valid = 1'b1;
`endif
            break;
         end
         if (abort_after > 0 && n == abort_after) begin
            snap_abort = 1'b1;
            tick();
            snap_abort = 1'b0;
            chk("abort_valid", px_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_we", write_enable, 0);
            repeat (15) begin
               tick();
               if (snap_done || snap_err || px_valid) dones++;
            end
            chk("abort_quiet", dones, 0);
`ifdef FRAME_CRC_EN
            crc_valid = 1'b0;
`endif
            aborted = 1'b1;
            break;
         end
         case (mode)
            0: px_ready = 1'b1;
            1: px_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: px_ready = 1'($urandom_range(0, 1));
         endcase
         if (px_valid && px_ready) begin
            if (n < NP) begin
               chk("pix_data", px_data, mem[n]);
               chk("pix_sop", px_sop, n == 0);
               chk("pix_eop", px_eop, n == NP - 1);
               crc_m = crc_ref(crc_m, mem[n]);
            end
            if (n == 0) first = cyc;
            if (n == NP - 1) begin
               last     = cyc;
               done_cyc = cyc;
            end
            n++;
         end
         stalled = px_valid && !px_ready;
         held    = {px_sop, px_eop, px_data};
         tick();
      end
      px_ready = 1'b1;
      if (!aborted) begin
         chk("pix_count", n, NP);
         chk("done_count", dones, 1);
         chk("addr_limit", max_addr, NP);
         if (mode == 0) begin
            chk("first_valid_latency", first, 10);
            chk("back_to_back", last - first, NP - 1);
         end
      end
   endtask

   initial begin
      int c;
      bit we_seen;
      new_frame();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_ctrl", {write_enable, px_valid, px_sop, px_eop, busy, snap_done, snap_err}, 0);
      chk("rst_data", {px_data, retrieve_address}, 0);
      reset = 1'b0;
      tick();

      do_capture(1'b0);
      readout(0, 0);
      do_capture(1'b1);
      readout(1, 0);
      do_capture(1'b0);
      readout(2, 0);

      // No vsync at all: the wait must time out.
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      c = 0;
      we_seen = 1'b0;
      while (!snap_err && c < 150) begin
         tick();
         c++;
         if (write_enable) we_seen = 1'b1;
      end
      chk("timeout_cycles", c, 100);
      chk("timeout_we", we_seen, 0);
      chk("timeout_busy", busy, 0);
      tick();
      chk("err_one_cycle", snap_err, 0);

      // Abort during capture, then a request coinciding with an abort.
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      repeat (3) tick();
      ov7670_vsync = 1'b1;
      repeat (4) tick();
      chk("cap_we", write_enable, 1);
      ov7670_vsync = 1'b0;
      repeat (3) tick();
      snap_abort = 1'b1;
      tick();
      snap_abort = 1'b0;
      chk("cap_abort_we", write_enable, 0);
      chk("cap_abort_busy", busy, 0);
      snap_req = 1'b1;
      snap_abort = 1'b1;
      tick();
      snap_req = 1'b0;
      snap_abort = 1'b0;
      chk("req_with_abort", busy, 0);
      tick();

      do_capture(1'b0);
      readout(0, 5);
      do_capture(1'b0);
      readout(0, 0);

      // Asynchronous reset in the middle of readout.
      do_capture(1'b0);
      repeat (13) tick();
      chk("pre_reset_valid", px_valid, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_ctrl", {write_enable, px_valid, px_sop, px_eop, busy, snap_done, snap_err}, 0);
      chk("async_rst_data", {px_data, retrieve_address}, 0);
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_snapshot_ctrl.md
Name: frame_snapshot_ctrl

Overview:
Sequences single-frame snapshots from the OV7670 capture path into the frame buffer, then streams the frozen frame out for the WiFi sender. It drives the capture top's write_enable and the read side of the clk_50 frame buffer port (retrieve_address/output_data). Frame boundaries come from the camera vsync, which is resynchronised internally. Output is a valid/ready pixel stream with sop/eop.

Parameters:
NUM_PIXELS, 76800, pixels per frame (320x240); last address = NUM_PIXELS-1
ADDR_W, 17, frame buffer address width
PIX_W, 12, pixel width (RGB444)
SETTLE_CYCLES, 8, clk_50 cycles after capture end before readout (drains pclk-domain writes)
TIMEOUT_CYCLES, 5000000, max cycles waiting for a vsync edge (100 ms at 50 MHz)

Ports:
clk_50  in  1  system clock; every flop in this block is clocked by it
reset  in  1  asynchronous, active-high reset
snap_req  in  1  one-cycle request to start a snapshot; ignored unless IDLE
snap_abort  in  1  return to IDLE from any state
ov7670_vsync  in  1  raw camera vsync (pclk domain, asynchronous here)
write_enable  out  1  frame buffer write gate to the capture top
retrieve_address  out  ADDR_W  frame buffer read address
output_data  in  PIX_W  frame buffer read data; valid exactly 1 cycle after its address
px_data  out  PIX_W  stream pixel
px_valid  out  1  stream valid
px_ready  in  1  stream ready from the consumer
px_sop  out  1  qualifies the pixel at address 0
px_eop  out  1  qualifies the pixel at address NUM_PIXELS-1
busy  out  1  high whenever state != IDLE
snap_done  out  1  one-cycle pulse after eop handshake
snap_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, FIFO and in-flight flag cleared.
- vsync is synchronised by 2 flops; vs_rise = sync high and previous sync low (3-cycle detection latency).
- States:
  - IDLE: on snap_req go to WAIT_VS and clear the timeout counter.
  - WAIT_VS: on vs_rise go to CAPTURE and set write_enable the following cycle.
  - CAPTURE: write_enable=1. On the next vs_rise, clear write_enable (registered) and go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to READOUT with rd_addr=0.
  - READOUT: stream as described below. On the handshake of the eop pixel, go to DONE.
  - DONE: pulse snap_done for 1 cycle, then go to IDLE.
- Timeout: in WAIT_VS or CAPTURE, the counter increments every cycle and restarts on each state entry. When it reaches TIMEOUT_CYCLES-1 with no vs_rise: pulse snap_err, set write_enable=0, go to IDLE.
- snap_abort has priority over all transitions. Next cycle: IDLE, write_enable=0, px_valid=0, FIFO flushed, no done or err pulse. A read in flight is discarded.
- A snap_req while busy is ignored. A snap_req in the same cycle as snap_abort is ignored.
- Readout pipeline:
  - retrieve_address = rd_addr (registered).
  - A read issues when occupancy + inflight < 2 and rd_addr <= NUM_PIXELS-1.
  - Each issued read's data enters a 2-entry FIFO one cycle later.
  - px_valid = FIFO not empty; px_data, px_sop and px_eop come from the FIFO head. sop/eop are tagged from the address at issue time.
  - Handshake = px_valid & px_ready. The head pops and a push may happen in the same cycle.
  - px_data/sop/eop hold stable while px_valid=1 and px_ready=0.
  - Sustained throughput is 1 pixel/cycle with px_ready held high. First px_valid appears 2 cycles after READOUT entry.
- rd_addr stops at NUM_PIXELS (no wrap). Reads never exceed NUM_PIXELS-1.
- busy = (state != IDLE), registered.

Optional Feature:
FRAME_CRC_EN:
- Adds output crc16 [15:0] and computes CRC-16-CCITT over every handshaked pixel.
- Pixel is zero-extended to 16 bits, processed MSB first; poly 0x1021, init 0xFFFF, no reflection, no final xor.
- CRC resets to 0xFFFF on READOUT entry. crc16 holds its final value from the snap_done pulse until the next READOUT entry.
- Without the macro: no crc16 port and no CRC logic.

Test Plan:
- NUM_PIXELS=16, vsync rises at t0 and t1, px_ready=1:
  - write_enable high from 4 cycles after t0 edge, low 4 cycles after t1 edge.
  - 16 pixels on consecutive cycles, addresses 0..15 in order; sop on pixel 0, eop on pixel 15.
  - snap_done 1 cycle after eop handshake.
- Same setup with px_ready toggling 1,0,0,1 repeatedly: all 16 pixels delivered exactly once, data stable during stalls, FIFO never overflows.
- TIMEOUT_CYCLES=100, no vsync after snap_req: snap_err pulses 100 cycles later, write_enable stays 0, busy falls.
- snap_abort in CAPTURE: write_enable=0 next cycle. snap_abort mid-READOUT after 5 pixels: px_valid=0 next cycle, no snap_done. A new snap_req then restarts from address 0.
- snap_req while busy in CAPTURE: ignored, exactly one snap_done. Reset asserted mid-READOUT: all outputs 0 immediately (asynchronous).
- FRAME_CRC_EN, pixels 0x000..0x00F: crc16 equals the bench reference model at snap_done and holds until the next snapshot.
